// File: rtl/score_display_seq.sv
`default_nettype none
// ============================================================================
//  Module   : score_display_seq
//  Purpose  : Converts two binary player scores to decimal with a sequential
//             shift-add-3 (double-dabble) engine and drives 2*DIGITS
//             active-low seven-segment digits. Supports optional leading-zero
//             blanking and blinking of the winning player's digits.
//  Ports    : clk      - system clock
//             reset    - synchronous active-high reset
//             score_a  - player A binary score (SCORE_W bits)
//             score_b  - player B binary score (SCORE_W bits)
//             update   - single-cycle request to latch and convert both scores
//             winner   - 00 none, 01 A, 10 B, 11 both blink
//             busy     - high while a conversion is in progress
//             hex_out  - active-low segments, digit k at [7k+6:7k] (gfedcba);
//                        digits 0..DIGITS-1 = A, DIGITS..2*DIGITS-1 = B
//  Revision : 1.0 - initial release
// ============================================================================
module score_display_seq #(
    parameter int SCORE_W   = 7,
    parameter int DIGITS    = 3,
    parameter int BLINK_DIV = 25000000,
    parameter int BLANK_LZ  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SCORE_W-1:0]    score_a,
    input  logic [SCORE_W-1:0]    score_b,
    input  logic                  update,
    input  logic [1:0]            winner,
    output logic                  busy,
    output logic [14*DIGITS-1:0]  hex_out
);

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam longint c_MAX   = pow10(DIGITS) - 1;
    localparam int     c_BCD_W = 4 * DIGITS;
    localparam int     c_SEG_W = 7 * DIGITS;
    localparam int     c_CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
    localparam int     c_BLK_W = $clog2(BLINK_DIV);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_CONVERT = 2'd1;
    localparam logic [1:0] c_ST_COMMIT  = 2'd2;

    // One double-dabble iteration: correct every nibble that would exceed 9
    // after doubling, then shift the whole {bcd, binary} pair left by one.
    function automatic logic [c_BCD_W+SCORE_W-1:0] dd_step(
        input logic [c_BCD_W-1:0] bcd,
        input logic [SCORE_W-1:0] sh
    );
        logic [c_BCD_W-1:0] adj;
        adj = bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
        return {adj, sh} << 1;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Scans from the most significant digit down; a digit is blanked while
    // it and every digit above it are zero. The ones digit is always shown.
    function automatic logic [c_SEG_W-1:0] encode(input logic [c_BCD_W-1:0] bcd);
        logic [c_SEG_W-1:0] seg;
        logic               lead;
        seg  = '0;
        lead = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lead = lead && (bcd[4*k +: 4] == 4'd0);
            if ((BLANK_LZ != 0) && lead && (k != 0)) seg[7*k +: 7] = 7'h7F;
            else                                     seg[7*k +: 7] = seg7(bcd[4*k +: 4]);
        end
        return seg;
    endfunction

    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [SCORE_W-1:0]  r_sh_a, r_sh_b;
    logic [c_BCD_W-1:0]  r_bcd_a, r_bcd_b;
    logic                r_busy;
    logic [c_SEG_W-1:0]  r_dig_a, r_dig_b;
    logic [c_BLK_W-1:0]  r_blk_cnt;
    logic                r_phase;

    logic [SCORE_W-1:0]  w_sat_a, w_sat_b;
    logic                w_mask_a, w_mask_b;

    // Clamp to the largest value the display can show.
    assign w_sat_a = (64'(score_a) > 64'(c_MAX)) ? SCORE_W'(c_MAX) : score_a;
    assign w_sat_b = (64'(score_b) > 64'(c_MAX)) ? SCORE_W'(c_MAX) : score_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_bcd_a <= '0;
            r_bcd_b <= '0;
            r_busy  <= 1'b0;
            r_dig_a <= '1;
            r_dig_b <= '1;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (update) begin
                        r_sh_a  <= w_sat_a;
                        r_sh_b  <= w_sat_b;
                        r_bcd_a <= '0;
                        r_bcd_b <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_CONVERT;
                    end
                end
                c_ST_CONVERT: begin
                    {r_bcd_a, r_sh_a} <= dd_step(r_bcd_a, r_sh_a);
                    {r_bcd_b, r_sh_b} <= dd_step(r_bcd_b, r_sh_b);
                    if (r_cnt == c_CNT_W'(SCORE_W - 1)) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_COMMIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_COMMIT: begin
                    r_dig_a <= encode(r_bcd_a);
                    r_dig_b <= encode(r_bcd_b);
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Blink timebase: free-runs only while some player is selected; a change
    // between non-zero winner codes leaves it running undisturbed.
    always_ff @(posedge clk) begin
        if (reset || (winner == 2'b00)) begin
            r_blk_cnt <= '0;
            r_phase   <= 1'b0;
        end else if (r_blk_cnt == c_BLK_W'(BLINK_DIV - 1)) begin
            r_blk_cnt <= '0;
            r_phase   <= ~r_phase;
        end else begin
            r_blk_cnt <= r_blk_cnt + 1'b1;
        end
    end

    // Blank is all-ones, so masking is a plain OR over the stored digits.
    assign w_mask_a = r_phase & winner[0];
    assign w_mask_b = r_phase & winner[1];

    assign busy    = r_busy;
    assign hex_out = {r_dig_b | {c_SEG_W{w_mask_b}}, r_dig_a | {c_SEG_W{w_mask_a}}};

endmodule
`default_nettype wire

// File: tb/tb_score_display_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_display_seq
//  Purpose  : Self-checking bench for score_display_seq. Three instances
//             (default, no blanking, two digits) share stimulus; expected
//             displays are queued at issue and checked when busy falls.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_score_display_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        update;
    logic [6:0]  sa, sb;
    logic [1:0]  winner;
    logic        busy0, busy1, busy2;
    logic [41:0] hex0, hex1;
    logic [27:0] hex2;

    int errors = 0;
    int checks = 0;

    logic [41:0] q0[$];
    logic [41:0] q1[$];
    logic [27:0] q2[$];

    localparam logic [41:0] c_BLANK42 = {6{7'h7F}};
    localparam logic [27:0] c_BLANK28 = {4{7'h7F}};

    always #5 clk = ~clk;

    score_display_seq #(.SCORE_W(7), .DIGITS(3), .BLINK_DIV(4), .BLANK_LZ(1)) dut0 (
        .clk(clk), .reset(reset), .score_a(sa), .score_b(sb), .update(update),
        .winner(winner), .busy(busy0), .hex_out(hex0));

    score_display_seq #(.SCORE_W(7), .DIGITS(3), .BLINK_DIV(4), .BLANK_LZ(0)) dut1 (
        .clk(clk), .reset(reset), .score_a(sa), .score_b(sb), .update(update),
        .winner(winner), .busy(busy1), .hex_out(hex1));

    score_display_seq #(.SCORE_W(7), .DIGITS(2), .BLINK_DIV(4), .BLANK_LZ(1)) dut2 (
        .clk(clk), .reset(reset), .score_a(sa), .score_b(sb), .update(update),
        .winner(winner), .busy(busy2), .hex_out(hex2));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got commit expected none", name);
    endtask

    // Monitors: a falling busy outside reset is a committed display.
    logic pb0 = 1'b0, pb1 = 1'b0, pb2 = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!reset && pb0 && !busy0) begin
            if (q0.size() == 0) unexpected("dut0 commit");
            else chk("dut0 commit", 64'(hex0), 64'(q0.pop_front()));
        end
        if (!reset && pb1 && !busy1) begin
            if (q1.size() == 0) unexpected("dut1 commit");
            else chk("dut1 commit", 64'(hex1), 64'(q1.pop_front()));
        end
        if (!reset && pb2 && !busy2) begin
            if (q2.size() == 0) unexpected("dut2 commit");
            else chk("dut2 commit", 64'(hex2), 64'(q2.pop_front()));
        end
        pb0 = busy0;
        pb1 = busy1;
        pb2 = busy2;
    end

    // Returns at the negedge following the sampling edge E0.
    task automatic issue(input logic [6:0] a, input logic [6:0] b);
        @(negedge clk);
        sa     = a;
        sb     = b;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic expect3(input logic [41:0] e0, input logic [41:0] e1, input logic [27:0] e2);
        q0.push_back(e0);
        q1.push_back(e1);
        q2.push_back(e2);
    endtask

    // Counts edges from E0 until busy drops; expects SCORE_W+1 = 8.
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 64'(n), 64'd8);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ph;
        logic [41:0] full;
        reset  = 1'b1;
        update = 1'b0;
        sa     = '0;
        sb     = '0;
        winner = 2'b00;

        // Reset for two cycles with an update pulse that must be ignored.
        @(negedge clk);
        sa = 7'd42;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        chk("reset hex0", 64'(hex0), 64'(c_BLANK42));
        chk("reset hex1", 64'(hex1), 64'(c_BLANK42));
        chk("reset hex2", 64'(hex2), 64'(c_BLANK28));
        chk("reset busy", 64'(busy0), 64'd0);
        reset = 1'b0;
        cycles(3);
        chk("post-reset busy", 64'(busy0), 64'd0);
        chk("post-reset hex0", 64'(hex0), 64'(c_BLANK42));

        // Basic 42 / 7.
        expect3({7'h7F, 7'h7F, 7'h78, 7'h7F, 7'h19, 7'h24},
                {7'h40, 7'h40, 7'h78, 7'h40, 7'h19, 7'h24},
                {7'h7F, 7'h78, 7'h19, 7'h24});
        issue(7'd42, 7'd7);
        wait_idle("busy cycles 42/7");

        // Zero on A, 99 on B.
        expect3({7'h7F, 7'h10, 7'h10, 7'h7F, 7'h7F, 7'h40},
                {7'h40, 7'h10, 7'h10, 7'h40, 7'h40, 7'h40},
                {7'h10, 7'h10, 7'h7F, 7'h40});
        issue(7'd0, 7'd99);
        wait_idle("busy cycles 0/99");

        // 127 / 100: fits three digits, saturates two.
        expect3({7'h79, 7'h40, 7'h40, 7'h79, 7'h24, 7'h78},
                {7'h79, 7'h40, 7'h40, 7'h79, 7'h24, 7'h78},
                {7'h10, 7'h10, 7'h10, 7'h10});
        issue(7'd127, 7'd100);
        wait_idle("busy cycles 127/100");

        // Collisions: update at E3 and at E8 are both ignored.
        expect3({7'h79, 7'h24, 7'h40, 7'h7F, 7'h79, 7'h30},
                {7'h79, 7'h24, 7'h40, 7'h40, 7'h79, 7'h30},
                {7'h10, 7'h10, 7'h79, 7'h30});
        issue(7'd13, 7'd120);
        cycles(2);
        sa = 7'd5;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        chk("display hold", 64'(hex0), 64'({7'h79, 7'h40, 7'h40, 7'h79, 7'h24, 7'h78}));
        chk("busy mid-convert", 64'(busy0), 64'd1);
        cycles(4);
        sa = 7'd9;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        chk("busy after E8", 64'(busy0), 64'd0);
        cycles(2);
        chk("update at E8 ignored", 64'(busy0), 64'd0);

        // Reset at E4 aborts without commit.
        issue(7'd1, 7'd2);
        cycles(3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort hex0", 64'(hex0), 64'(c_BLANK42));
        chk("abort hex2", 64'(hex2), 64'(c_BLANK28));
        chk("abort busy", 64'(busy0), 64'd0);
        cycles(12);
        chk("abort stays idle", 64'(busy0), 64'd0);

        // Blink on A with BLINK_DIV=4.
        full = {7'h7F, 7'h7F, 7'h78, 7'h7F, 7'h19, 7'h24};
        expect3(full,
                {7'h40, 7'h40, 7'h78, 7'h40, 7'h19, 7'h24},
                {7'h7F, 7'h78, 7'h19, 7'h24});
        issue(7'd42, 7'd7);
        wait_idle("busy cycles blink setup");
        @(negedge clk);
        winner = 2'b01;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            ph = ((i + 1) / 4) % 2;
            chk($sformatf("blink A cycle %0d", i), 64'(hex0),
                64'((ph == 1) ? {full[41:21], 21'h1FFFFF} : full));
        end
        @(negedge clk);
        winner = 2'b00;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("steady cycle %0d", i), 64'(hex0), 64'(full));
        end
        // Counter restart from 0 shows as the same 4-edge first half-period.
        @(negedge clk);
        winner = 2'b11;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            ph = ((i + 1) / 4) % 2;
            chk($sformatf("blink both cycle %0d", i), 64'(hex0),
                64'((ph == 1) ? c_BLANK42 : full));
        end
        @(negedge clk);
        winner = 2'b00;
        cycles(4);
        chk("scoreboard drained", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/score_display_seq.md
Name: score_display_seq

Overview:
- Parametrised, registered successor to the per-digit 7-segment decoder.
- Accepts two binary player scores and converts each to decimal with a sequential shift-add-3 (double-dabble) engine.
- Drives 2*DIGITS active-low seven-segment digits, with optional leading-zero blanking and winner blinking.
- Sits between the game-logic score counters and the board HEX pins.

Parameters:
- SCORE_W, 7, bit width of each binary score input.
- DIGITS, 3, decimal digits per player; total digits = 2*DIGITS.
- BLINK_DIV, 25000000, clk cycles per blink half-period (minimum 2).
- BLANK_LZ, 1, 1 = blank leading zeros (ones digit always shown); 0 = show all zeros.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- score_a, input, SCORE_W, player A binary score.
- score_b, input, SCORE_W, player B binary score.
- update, input, 1, single-cycle request to latch and convert both scores.
- winner, input, 2, 00 none, 01 A, 10 B, 11 both blink.
- busy, output, 1, high while a conversion is in progress.
- hex_out, output, 14*DIGITS, active-low segments. Digit k occupies bits [7k+6:7k], bit order gfedcba (bit0 = a). Digits 0..DIGITS-1 are player A (digit 0 = ones); digits DIGITS..2*DIGITS-1 are player B.

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is synchronous and active-high, sampled on the rising edge of clk.
  - Reset values: busy=0; every digit 7'h7F (blank); blink counter=0, blink phase=0; state=IDLE.
  - Reset during CONVERT aborts the conversion with no commit.
- Segment codes (hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F.
- FSM states: IDLE, CONVERT, COMMIT.
- IDLE:
  - update=1 latches both scores into shift registers.
  - Each score saturates at latch to 10^DIGITS-1 if larger.
  - BCD accumulators are cleared, busy goes 1 at the same edge, and the FSM moves to CONVERT.
- CONVERT:
  - Exactly SCORE_W edges. Each edge performs add-3 on every BCD nibble >=5, then shifts left one bit, for both players in parallel.
  - The shift counter wraps to COMMIT after SCORE_W shifts.
- COMMIT:
  - One edge: BCD results are encoded into the digit registers (with blanking), busy goes 0, and the FSM returns to IDLE.
- Latency:
  - update sampled at edge E0; hex_out and busy=0 change at edge E(SCORE_W+1).
  - busy is high for SCORE_W+1 cycles.
- Update while busy:
  - update while busy=1 is ignored (not queued).
  - update in the same cycle busy falls is also ignored, because the FSM is not yet in IDLE.
- Input stability: score inputs are sampled only at the latch edge; later changes have no effect until the next update.
- Leading-zero blanking (BLANK_LZ=1):
  - A digit is blank if it and all higher digits of the same player are 0; digit 0 is never blanked.
  - Score 0 shows a single "0".
- Blink:
  - When winner!=00, the counter runs 0..BLINK_DIV-1 and phase toggles at wrap.
  - When phase=1, all digits of the selected player(s) read 7F at hex_out. This is combinational masking over the registered digits; the stored values are unchanged.
  - When winner=00, the counter and phase are held at 0 and no masking applies.
  - A change of winner does not restart a counter that is already running.
- Display hold: hex_out keeps the previous committed value throughout CONVERT.

Test Plan:
- Reset: assert reset 2 cycles -> hex_out all 7F, busy=0; update pulsed with reset high -> ignored.
- Basic conversion: score_a=42, score_b=7, update pulse (defaults) -> busy high 8 cycles. Then A digits {d2,d1,d0}={7F,19,24} and B digits {7F,7F,78}.
- Zero and no blanking: score_a=0 with BLANK_LZ=1 -> A={7F,7F,40}. Same stimulus with BLANK_LZ=0 -> A={40,40,40}.
- Saturation: DIGITS=2, score_a=127 -> A={10,10} ("99"); score_b=100 -> B={10,10}.
- Update collisions: update at E0, second update at E3 with score_a=5 -> only the first scores appear at E8. Reset at E4 -> hex_out all 7F and busy=0 after the reset edge, no commit.
- Blink: BLINK_DIV=4, winner=01 after committing 42/7 -> A digits alternate 7F / {7F,19,24} every 4 cycles while B is steady. winner=00 -> A steady, counter=0.
